// File: rtl/encoder_pkg.sv
// Shared constants and phase helpers for the carriage encoder front end.
package encoder_pkg;

  localparam int DEF_FILTER_LEN = 4;
  localparam int DEF_WINDOW     = 5120;
  localparam int DEF_CNT_W      = 16;

  // Phase is {A, B}; forward travel walks 00 -> 10 -> 11 -> 01 -> 00.
  typedef logic [1:0] phase_t;

  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_10 = 2'b10;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_01 = 2'b01;

  function automatic logic [1:0] phase_idx(input phase_t ph);
    case (ph)
      PH_00:   return 2'd0;
      PH_10:   return 2'd1;
      PH_11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic is_forward(input phase_t prev, input phase_t cur);
    return phase_idx(cur) == (phase_idx(prev) + 2'd1);
  endfunction

endpackage

// File: rtl/encoder_line_counter_if.sv
// Link between the encoder front end and the printer-head controller.
// StepPulse and RateValid are single-cycle qualifiers with no back-pressure:
// the controller must sample LineRate in the cycle RateValid is high.
interface encoder_line_counter_if
  import encoder_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             CountClear;
  logic [CNT_W-1:0] LineCounter;
  logic             Direction;
  logic             StepPulse;
  logic             PhaseError;
  logic [CNT_W-1:0] LineRate;
  logic             RateValid;

  modport master (
    input  CountClear,
    output LineCounter, Direction, StepPulse, PhaseError, LineRate, RateValid
  );

  modport slave (
    output CountClear,
    input  LineCounter, Direction, StepPulse, PhaseError, LineRate, RateValid
  );
endinterface

// File: rtl/enc_glitch_filter.sv
// One encoder channel: two-flop synchroniser followed by a persistence filter
// that only accepts a level after FILTER_LEN consecutive differing cycles.
module enc_glitch_filter
  import encoder_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic CLK,
  input  logic RST,
  input  logic Din,
  output logic Dout
);

  localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

  logic       sync1;
  logic       sync2;
  logic [3:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= 4'd0;
      Dout  <= 1'b0;
    end else begin
      sync1 <= Din;
      sync2 <= sync1;
      if (sync2 == Dout) begin
        cnt <= 4'd0;
      end else if (cnt == CNT_LAST) begin
        // This cycle is the FILTER_LEN-th consecutive disagreement.
        Dout <= sync2;
        cnt  <= 4'd0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/encoder_line_counter.sv
// Quadrature decode, saturating line counter and lines-per-window rate meter
// feeding the printer-head controller.
module encoder_line_counter
  import encoder_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN,
  parameter int WINDOW     = DEF_WINDOW,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EncA,
  input  logic                  EncB,
  encoder_line_counter_if.master ctl
);

  localparam int               WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             filt_a;
  logic             filt_b;
  phase_t           cur_ph;
  phase_t           prev_ph;
  phase_t           ph_diff;
  logic             step;
  logic             dbl;

  logic [CNT_W-1:0] line_cnt;
  logic             direction;
  logic             step_pulse;
  logic             phase_err;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_sum;
  logic [CNT_W-1:0] line_rate;
  logic             rate_valid;

  enc_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .CLK(CLK), .RST(RST), .Din(EncA), .Dout(filt_a)
  );

  enc_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .CLK(CLK), .RST(RST), .Din(EncB), .Dout(filt_b)
  );

  assign cur_ph  = {filt_a, filt_b};
  assign ph_diff = cur_ph ^ prev_ph;
  assign step    = ^ph_diff;
  assign dbl     = &ph_diff;

  // Distance is unsigned: both directions advance the counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_ph    <= PH_00;
      step_pulse <= 1'b0;
      direction  <= 1'b0;
      line_cnt   <= '0;
      phase_err  <= 1'b0;
    end else begin
      prev_ph    <= cur_ph;
      step_pulse <= step;
      if (step) direction <= is_forward(prev_ph, cur_ph);
      if (ctl.CountClear)                   line_cnt <= '0;
      else if (step && line_cnt != CNT_MAX) line_cnt <= line_cnt + CNT_W'(1);
      if (ctl.CountClear) phase_err <= 1'b0;
      else if (dbl)       phase_err <= 1'b1;
    end
  end

  // The terminal cycle's own step is folded into the published rate.
  assign acc_sum = (acc == CNT_MAX) ? CNT_MAX : acc + CNT_W'(step_pulse);

  always_ff @(posedge CLK) begin
    if (RST) begin
      win_cnt    <= '0;
      acc        <= '0;
      line_rate  <= '0;
      rate_valid <= 1'b0;
    end else begin
      rate_valid <= (win_cnt == WIN_LAST);
      if (win_cnt == WIN_LAST) begin
        win_cnt   <= '0;
        acc       <= '0;
        line_rate <= acc_sum;
      end else begin
        win_cnt <= win_cnt + WIN_W'(1);
        acc     <= acc_sum;
      end
    end
  end

  assign ctl.LineCounter = line_cnt;
  assign ctl.Direction   = direction;
  assign ctl.StepPulse   = step_pulse;
  assign ctl.PhaseError  = phase_err;
  assign ctl.LineRate    = line_rate;
  assign ctl.RateValid   = rate_valid;

endmodule

// File: tb/tb_encoder_line_counter.sv
// Directed bench for encoder_line_counter: a 16-bit instance for the main
// features and a 3-bit instance sharing the encoder inputs for saturation.
module tb_encoder_line_counter;
  import encoder_pkg::*;

  localparam int FL  = 4;
  localparam int WIN = 100;
  localparam int CW  = 16;
  localparam int SW  = 3;

  logic CLK = 1'b0;
  logic RST;
  logic EncA;
  logic EncB;

  encoder_line_counter_if #(.CNT_W(CW)) ctl_if ();
  encoder_line_counter_if #(.CNT_W(SW)) sat_if ();

  encoder_line_counter #(.FILTER_LEN(FL), .WINDOW(WIN), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .EncA(EncA), .EncB(EncB), .ctl(ctl_if)
  );

  encoder_line_counter #(.FILTER_LEN(FL), .WINDOW(WIN), .CNT_W(SW)) dut_sat (
    .CLK(CLK), .RST(RST), .EncA(EncA), .EncB(EncB), .ctl(sat_if)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int pulse_cnt;
  int first_pulse;
  logic [1:0] cur_ph;
  logic [CW-1:0] exp_q[$];

  function automatic logic [1:0] next_fwd(input logic [1:0] ph);
    case (ph)
      PH_00:   return PH_10;
      PH_10:   return PH_11;
      PH_11:   return PH_01;
      default: return PH_00;
    endcase
  endfunction

  function automatic logic [1:0] next_rev(input logic [1:0] ph);
    case (ph)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      default: return PH_00;
    endcase
  endfunction

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic tick_count(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (ctl_if.StepPulse) pulse_cnt++;
    end
  endtask

  // Input first sampled at the next rising edge; the pulse is due 6 edges
  // after that, i.e. at the 7th falling-edge sample.
  task automatic apply_phase(input logic [1:0] ph, input int hold, input bit chk_lat);
    EncA = ph[1];
    EncB = ph[0];
    cur_ph = ph;
    first_pulse = -1;
    for (int i = 1; i <= hold; i++) begin
      tick();
      if (ctl_if.StepPulse) begin
        pulse_cnt++;
        if (first_pulse < 0) first_pulse = i;
      end
    end
    if (chk_lat) begin
      checks++;
      if (first_pulse !== 7) begin
        errors++;
        $display("FAIL step_latency got %0d expected 7", first_pulse);
      end
    end
  endtask

  task automatic test_reset();
    int first_rv;
    RST = 1'b1;
    EncA = 1'b0;
    EncB = 1'b0;
    cur_ph = PH_00;
    ctl_if.CountClear = 1'b0;
    sat_if.CountClear = 1'b0;
    repeat (3) tick();
    checks++;
    if ({ctl_if.LineCounter, ctl_if.Direction, ctl_if.StepPulse, ctl_if.PhaseError,
         ctl_if.LineRate, ctl_if.RateValid} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got cnt=%0d dir=%0b sp=%0b pe=%0b rate=%0d rv=%0b expected all 0",
               ctl_if.LineCounter, ctl_if.Direction, ctl_if.StepPulse, ctl_if.PhaseError,
               ctl_if.LineRate, ctl_if.RateValid);
    end
    RST = 1'b0;
    first_rv = -1;
    for (int i = 1; i <= 150; i++) begin
      tick();
      if (ctl_if.RateValid) begin
        first_rv = i;
        break;
      end
    end
    checks++;
    if (first_rv !== WIN) begin
      errors++;
      $display("FAIL first_rate_valid got edge %0d expected %0d", first_rv, WIN);
    end
    checks++;
    if (ctl_if.LineRate !== 16'd0) begin
      errors++;
      $display("FAIL idle_rate got %0d expected 0", ctl_if.LineRate);
    end
    tick();
    checks++;
    if (ctl_if.RateValid !== 1'b0) begin
      errors++;
      $display("FAIL rate_valid_width got %0b expected 0", ctl_if.RateValid);
    end
  endtask

  task automatic test_forward();
    pulse_cnt = 0;
    for (int r = 0; r < 10; r++)
      for (int p = 0; p < 4; p++) apply_phase(next_fwd(cur_ph), 8, 1'b1);
    checks++;
    if (ctl_if.LineCounter !== 16'd40) begin
      errors++;
      $display("FAIL fwd_count got %0d expected 40", ctl_if.LineCounter);
    end
    checks++;
    if (ctl_if.Direction !== 1'b1) begin
      errors++;
      $display("FAIL fwd_direction got %0b expected 1", ctl_if.Direction);
    end
    checks++;
    if (pulse_cnt !== 40) begin
      errors++;
      $display("FAIL fwd_pulses got %0d expected 40", pulse_cnt);
    end
  endtask

  task automatic test_glitch();
    pulse_cnt = 0;
    EncA = 1'b1;
    tick_count(3);
    EncA = 1'b0;
    tick_count(12);
    checks++;
    if (pulse_cnt !== 0 || ctl_if.LineCounter !== 16'd40) begin
      errors++;
      $display("FAIL glitch_3 got pulses=%0d cnt=%0d expected pulses=0 cnt=40",
               pulse_cnt, ctl_if.LineCounter);
    end
    EncA = 1'b1;
    tick_count(4);
    EncA = 1'b0;
    tick_count(12);
    checks++;
    if (pulse_cnt !== 2 || ctl_if.LineCounter !== 16'd42) begin
      errors++;
      $display("FAIL pulse_4 got pulses=%0d cnt=%0d expected pulses=2 cnt=42",
               pulse_cnt, ctl_if.LineCounter);
    end
    checks++;
    if (ctl_if.Direction !== 1'b0) begin
      errors++;
      $display("FAIL pulse_4_direction got %0b expected 0", ctl_if.Direction);
    end
  endtask

  task automatic test_reverse();
    ctl_if.CountClear = 1'b1;
    tick();
    ctl_if.CountClear = 1'b0;
    checks++;
    if (ctl_if.LineCounter !== 16'd0) begin
      errors++;
      $display("FAIL clear got %0d expected 0", ctl_if.LineCounter);
    end
    pulse_cnt = 0;
    for (int r = 0; r < 5; r++)
      for (int p = 0; p < 4; p++) apply_phase(next_rev(cur_ph), 8, 1'b1);
    checks++;
    if (ctl_if.LineCounter !== 16'd20 || ctl_if.Direction !== 1'b0 || pulse_cnt !== 20) begin
      errors++;
      $display("FAIL reverse got cnt=%0d dir=%0b pulses=%0d expected cnt=20 dir=0 pulses=20",
               ctl_if.LineCounter, ctl_if.Direction, pulse_cnt);
    end
  endtask

  task automatic test_phase_error();
    pulse_cnt = 0;
    apply_phase(PH_11, 10, 1'b0);
    checks++;
    if (ctl_if.PhaseError !== 1'b1 || ctl_if.LineCounter !== 16'd20 ||
        pulse_cnt !== 0 || ctl_if.Direction !== 1'b0) begin
      errors++;
      $display("FAIL double_change got pe=%0b cnt=%0d pulses=%0d dir=%0b expected pe=1 cnt=20 pulses=0 dir=0",
               ctl_if.PhaseError, ctl_if.LineCounter, pulse_cnt, ctl_if.Direction);
    end
    // 11 -> 01 is a forward step; clear lands in the same cycle as its count.
    EncA = 1'b0;
    cur_ph = PH_01;
    repeat (6) tick();
    ctl_if.CountClear = 1'b1;
    tick();
    ctl_if.CountClear = 1'b0;
    checks++;
    if (ctl_if.LineCounter !== 16'd0 || ctl_if.PhaseError !== 1'b0 ||
        ctl_if.StepPulse !== 1'b1 || ctl_if.Direction !== 1'b1) begin
      errors++;
      $display("FAIL clear_with_step got cnt=%0d pe=%0b sp=%0b dir=%0b expected cnt=0 pe=0 sp=1 dir=1",
               ctl_if.LineCounter, ctl_if.PhaseError, ctl_if.StepPulse, ctl_if.Direction);
    end
    repeat (4) tick();
    apply_phase(next_fwd(cur_ph), 8, 1'b1);
    checks++;
    if (ctl_if.LineCounter !== 16'd1) begin
      errors++;
      $display("FAIL count_after_clear got %0d expected 1", ctl_if.LineCounter);
    end
  endtask

  // The 3-bit instance preloaded to max-1 stands in for 65534 on 16 bits.
  task automatic test_saturation();
    sat_if.CountClear = 1'b1;
    tick();
    sat_if.CountClear = 1'b0;
    for (int i = 0; i < 6; i++) apply_phase(next_fwd(cur_ph), 8, 1'b0);
    checks++;
    if (sat_if.LineCounter !== 3'd6) begin
      errors++;
      $display("FAIL sat_preload got %0d expected 6", sat_if.LineCounter);
    end
    for (int i = 0; i < 3; i++) begin
      apply_phase(next_fwd(cur_ph), 8, 1'b0);
      checks++;
      if (sat_if.LineCounter !== 3'd7) begin
        errors++;
        $display("FAIL sat_hold step %0d got %0d expected 7", i, sat_if.LineCounter);
      end
    end
  endtask

  task automatic test_rate();
    int found;
    int rv_seen;
    logic [CW-1:0] exp_rate;
    found = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (ctl_if.RateValid) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (found == 0) begin
      errors++;
      $display("FAIL rate_sync got no RateValid expected one within 150 cycles");
      return;
    end
    exp_q.push_back(16'd10);
    exp_q.push_back(16'd10);
    rv_seen = 0;
    // Changes at t=2,12,..,192 give pulses at t=9,19,..,199, so each window's
    // last pulse sits on its terminal cycle.
    for (int t = 1; t <= 200; t++) begin
      tick();
      if (ctl_if.StepPulse) pulse_cnt++;
      if (ctl_if.RateValid) begin
        rv_seen++;
        checks++;
        if (t != 100 * rv_seen) begin
          errors++;
          $display("FAIL rate_period got t=%0d expected %0d", t, 100 * rv_seen);
        end
        exp_rate = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++;
        if (ctl_if.LineRate !== exp_rate) begin
          errors++;
          $display("FAIL line_rate got %0d expected %0d", ctl_if.LineRate, exp_rate);
        end
      end
      if (t % 10 == 2 && t <= 192) begin
        cur_ph = next_fwd(cur_ph);
        EncA = cur_ph[1];
        EncB = cur_ph[0];
      end
    end
    checks++;
    if (rv_seen !== 2) begin
      errors++;
      $display("FAIL rate_valid_count got %0d expected 2", rv_seen);
    end
    checks++;
    if (ctl_if.LineCounter !== 16'd30) begin
      errors++;
      $display("FAIL rate_count got %0d expected 30", ctl_if.LineCounter);
    end
  endtask

  task automatic test_mid_reset();
    RST = 1'b1;
    EncA = 1'b1;
    EncB = 1'b1;
    cur_ph = PH_11;
    tick();
    checks++;
    if ({ctl_if.LineCounter, ctl_if.Direction, ctl_if.StepPulse, ctl_if.PhaseError,
         ctl_if.LineRate, ctl_if.RateValid} !== '0) begin
      errors++;
      $display("FAIL mid_reset got cnt=%0d dir=%0b rate=%0d expected all 0",
               ctl_if.LineCounter, ctl_if.Direction, ctl_if.LineRate);
    end
    repeat (2) tick();
    RST = 1'b0;
    pulse_cnt = 0;
    tick_count(12);
    checks++;
    if (ctl_if.PhaseError !== 1'b1 || ctl_if.LineCounter !== 16'd0 || pulse_cnt !== 0) begin
      errors++;
      $display("FAIL rest_at_11 got pe=%0b cnt=%0d pulses=%0d expected pe=1 cnt=0 pulses=0",
               ctl_if.PhaseError, ctl_if.LineCounter, pulse_cnt);
    end
    ctl_if.CountClear = 1'b1;
    tick();
    ctl_if.CountClear = 1'b0;
    checks++;
    if (ctl_if.PhaseError !== 1'b0) begin
      errors++;
      $display("FAIL clear_phase_error got %0b expected 0", ctl_if.PhaseError);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_glitch();
    test_reverse();
    test_phase_error();
    test_saturation();
    test_rate();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder_line_counter.md
# encoder_line_counter

Front end for the printer-head carriage encoder: synchronises and glitch-filters the two quadrature channels, decodes them into a saturating line count, and measures lines per rate window. It sits directly upstream of the printer-head controller. It drives that controller's `LineCounter` input and obeys the controller's `LineCounterReset` output through `CountClear`.

## Interface
- `FILTER_LEN`, 4: consecutive cycles a synchronised level must differ from the filtered level before it is accepted (legal range 1..15)
- `WINDOW`, 5120: clock cycles per rate-measurement window (one second at the design clock)
- `CNT_W`, 16: width of `LineCounter` and `LineRate`
- `CLK`  in  1  system clock, all logic on rising edge
- `RST`  in  1  synchronous, active-high reset
- `EncA`  in  1  raw encoder channel A, asynchronous
- `EncB`  in  1  raw encoder channel B, asynchronous
- `CountClear`  in  1  synchronous clear of `LineCounter` (connected to `LineCounterReset`)
- `LineCounter`  out  CNT_W  accepted transitions since last clear, saturating
- `Direction`  out  1  direction of the last valid step: 1 = forward (A leads B), 0 = reverse
- `StepPulse`  out  1  one-cycle pulse per counted transition
- `PhaseError`  out  1  sticky flag: a double-channel transition was seen
- `LineRate`  out  CNT_W  steps counted in the last completed window
- `RateValid`  out  1  one-cycle pulse when `LineRate` updates

## Operation
- Reset values:
  - all outputs are 0;
  - sync flops, filtered levels, filter counters, previous-phase register, window counter and accumulator are all 0.
- Synchroniser: two flops per channel.
- Glitch filter, per channel:
  - A counter increments while the synchronised level differs from the filtered level.
  - The counter clears on any cycle where the two agree.
  - When the counter reaches `FILTER_LEN`, the filtered level takes the synchronised value and the counter clears.
- Decode: compare filtered {A,B} against the registered previous {A,B}.
  - Forward sequence is 00→10→11→01→00; reverse is the opposite order.
  - No change: no action.
  - Single-bit change: `LineCounter` += 1, saturating at 2^CNT_W−1. `StepPulse`=1. `Direction` is set from the sequence.
  - Both bits change: no count and no `StepPulse`. `PhaseError` sets and `Direction` holds.
  - The previous-phase register always updates to the current filtered phase.
- Counting is unsigned and direction-independent, because the controller measures travel distance per sweep.
- `CountClear`:
  - `LineCounter` goes to 0 on the next edge.
  - It wins over a simultaneous step: the result is 0, not 1, and `StepPulse` still fires.
  - It also clears `PhaseError`.
  - It does not touch the filters, the decode register or the rate logic.
- Rate:
  - The window counter runs 0..WINDOW−1 and wraps.
  - An accumulator counts `StepPulse` cycles, saturating at 2^CNT_W−1.
  - On the cycle with the window counter at WINDOW−1, `LineRate` ← accumulator plus that cycle's step, the accumulator ← 0, and `RateValid`=1.
  - The rate logic runs free and only `RST` affects it.

## Timing
- A new level on `EncA` that is first sampled at edge k produces `StepPulse` and the `LineCounter` update at edge k+FILTER_LEN+2.
  - Breakdown: 2 sync edges, then FILTER_LEN filter edges counted from the first differing synchronised cycle, then the decode register.
  - With default parameters this is 6 edges.
- A pulse shorter than `FILTER_LEN` cycles at the synchroniser output is rejected entirely.
- Maximum count rate is one step per `FILTER_LEN` cycles per channel.
- `RST` mid-operation returns everything to reset values on the next edge.
  - The first post-reset phase comparison is against 00.
  - If the encoder rests at 11 when reset is released, the first accepted phase is a double change: it sets `PhaseError` and does not count.
  - The controller is expected to issue `CountClear` before use.
- `RateValid` period is exactly `WINDOW` cycles; the first pulse comes `WINDOW` edges after reset release.

## Structure
- Shared package `encoder_pkg`:
  - phase encoding constants `PH_00`, `PH_10`, `PH_11`, `PH_01`;
  - default `FILTER_LEN`, `WINDOW`, `CNT_W`.
- Sub-module `enc_glitch_filter` contains one channel's synchroniser and filter (params `FILTER_LEN`; ports `CLK`, `RST`, `Din`, `Dout`). It is instantiated twice.
- Decode, saturating counter and rate logic stay in the top module.

## Test plan
- Forward quadrature 00→10→11→01→00 ×10, each phase held 8 cycles:
  - `LineCounter`=40, `Direction`=1, 40 `StepPulse`s;
  - each pulse comes 6 edges after its input change.
- `EncA` glitch of 3 cycles with `FILTER_LEN`=4 → no filtered change, `LineCounter` unchanged; a 4-cycle pulse gives 2 counts (rise and fall).
- Reverse sequence ×5 after a clear → `LineCounter`=20, `Direction`=0.
- Both channels toggled on the same cycle (00→11):
  - `PhaseError`=1, count unchanged;
  - then `CountClear` coincident with a valid step → `LineCounter`=0, `PhaseError`=0, `StepPulse`=1.
- Preload to 65534, apply 3 steps → `LineCounter` holds 65535.
- `WINDOW`=100 with steps every 10 cycles → `RateValid` every 100 cycles, `LineRate`=10; a step on the terminal cycle is included in that window's value.
